// File: rtl/change_logger.sv
// Change logger: timestamps every change of a monitored vector into a FIFO.
// Optional build macro CHANGE_LOGGER_MASK_EN adds a per-bit mask for change detection.

// Generic synchronous FIFO, head presented combinationally, reads 0 while empty.
// Latency: a push at edge N is visible at the head after edge N when empty.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [W-1:0]  push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign pop_vld  = (count != '0);
    assign do_pop   = pop_vld && pop_rdy;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign push_rdy = (count != CW'(DEPTH)) || do_pop;
    assign do_push  = push_vld && push_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Records {timestamp, value} on every change of sample_in; drops and counts events when full.
// Latency: change before edge N gives ev_valid after edge N when the FIFO was empty.
// Backpressure: ev_valid/ev_ready; a full FIFO without a pop drops the event (overflow, drop_cnt).
module change_logger #(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    sample_in,
`ifdef CHANGE_LOGGER_MASK_EN
    input  logic [WIDTH-1:0]    mask,
`endif
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [WIDTH-1:0]    ev_value,
    output logic [TS_WIDTH-1:0] ev_time,
    output logic [CW-1:0]       count,
    output logic                overflow,
    input  logic                clear_overflow,
    output logic [7:0]          drop_cnt
);
    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [WIDTH-1:0]    value;
    } event_t;

    logic [TS_WIDTH-1:0] ts_q;
    logic [WIDTH-1:0]    prev_q;
    logic                chg;
    logic                push_rdy;
    logic                drop;
    event_t              wr_ev;
    event_t              head_ev;

`ifdef CHANGE_LOGGER_MASK_EN
    assign chg = ((sample_in ^ prev_q) & mask) != '0;
`else
    assign chg = (sample_in != prev_q);
`endif

    assign wr_ev.ts    = ts_q;
    assign wr_ev.value = sample_in;
    assign drop        = chg && !push_rdy;

    sync_fifo #(
        .W     ($bits(event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (chg),
        .push_rdy (push_rdy),
        .push_dat (wr_ev),
        .pop_vld  (ev_valid),
        .pop_rdy  (ev_ready),
        .pop_dat  (head_ev),
        .count    (count)
    );

    assign ev_value = head_ev.value;
    assign ev_time  = head_ev.ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q   <= '0;
            prev_q <= '0;
        end else begin
            ts_q   <= ts_q + TS_WIDTH'(1);
            prev_q <= sample_in;
        end
    end

    // A drop on the same edge as a clear wins, restarting the count at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hff) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clear_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: doc/change_logger.md
Name: change_logger

Overview:
- Parametrised successor to the SoC LED-change monitor: watches a WIDTH-bit output vector (e.g. SOC LEDS) and records every change as a {timestamp, value} event.
- Events go into a DEPTH-entry FIFO, drained through a valid/ready handshake by a host-side UART dumper or a bench.
- Sits beside the SoC, on the same clock as the core.

Parameters:
- WIDTH, 5, width of monitored vector and of ev_value.
- DEPTH, 8, FIFO entries; power of two, >=2.
- TS_WIDTH, 16, free-running timestamp counter width, cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_in  input  WIDTH  monitored vector, synchronous to clk.
- ev_valid  output  1  FIFO head holds an event.
- ev_ready  input  1  consumer accepts head this cycle.
- ev_value  output  WIDTH  head event value.
- ev_time  output  TS_WIDTH  head event timestamp.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  output  1  sticky: at least one event dropped.
- clear_overflow  input  1  clears overflow and drop_cnt.
- drop_cnt  output  8  number of dropped events, saturating at 255.

Behaviour:
- Reset, asynchronous, active-high, any cycle including mid-drain:
  - ts_q=0, prev_q=0, FIFO pointers=0, count=0, ev_valid=0, overflow=0, drop_cnt=0.
  - ev_value and ev_time read 0 while empty.
- Timestamp: ts_q increments every cycle and wraps 2^TS_WIDTH-1 -> 0. No flag on wrap.
- Change detect:
  - chg = (sample_in != prev_q); prev_q <= sample_in every cycle.
  - Because prev_q resets to 0, a non-zero sample_in in the first cycle after reset logs an event.
- Push: on an edge where chg=1, entry {ts_q, sample_in} is written at wr_ptr. ts_q is the value before that edge's increment.
- Latency: sample_in changes before edge N -> ev_valid=1 after edge N, if the FIFO was empty.
- Pop: ev_valid && ev_ready at an edge advances rd_ptr. ev_value and ev_time are driven combinationally from the FIFO head register.
- ev_ready while ev_valid=0: ignored.
- Full (count==DEPTH) with chg=1:
  - Pop also occurring that edge: push accepted, count stays DEPTH.
  - No pop: event dropped; overflow<=1; drop_cnt increments, saturating at 255. FIFO contents unchanged.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- clear_overflow=1: overflow<=0 and drop_cnt<=0 at the edge. If a drop happens the same edge, the drop wins: overflow=1, drop_cnt=1.
- Outputs only change on clk edges or on reset assertion.

Optional Feature:
- Macro: CHANGE_LOGGER_MASK_EN.
- Defined:
  - Adds input port mask [WIDTH-1:0].
  - chg = ((sample_in ^ prev_q) & mask) != 0.
  - Logged ev_value is still the full unmasked sample_in.
  - prev_q still tracks all bits.
- Undefined: no mask port; every bit is monitored as above.

Test Plan:
- Reset, then sample_in=0 held 20 cycles -> ev_valid=0, count=0, overflow=0.
- Hold ev_ready=0. sample_in 0->5'b00011 before edge 10, then 5'b00111 before edge 13. Then ev_ready=1 -> two pops:
  - first pop: ev_value=00011, ev_time=9;
  - second pop: ev_value=00111, ev_time=12;
  - then count=0, ev_valid=0.
- DEPTH=8, ev_ready=0, toggle sample_in bit0 every cycle for 10 cycles -> count=8, overflow=1, drop_cnt=2. Drain -> 8 events with consecutive timestamps.
- Full FIFO, ev_ready=1 and a change on the same edge -> count stays 8, drop_cnt unchanged, new event appears last in drain order.
- TS_WIDTH=4: change before edges 15 and 17 -> ev_time 14 then 0, showing wrap.
- Assert reset mid-drain with count=3 -> count=0, ev_valid=0 immediately. Post-reset sample_in=5'b10000 -> one event with ev_time=0.
- With CHANGE_LOGGER_MASK_EN and mask=5'b00001: change bit4 only -> no event; then change bit0 -> one event with full value.
